// File: rtl/pwr_good_rst_seq_if.sv
// Signal bundle for the power-good qualifier: the level to qualify and the fault-clear
// pulse on one side, the sequenced reset and fault status on the other.
interface pwr_good_rst_seq_if;
    // There is no valid/ready pair. pg_in is a free-running asynchronous level.
    // fault_clr is a synchronous pulse that acts on every edge where it is high.
    // All status outputs are registered levels, except pg_lost, which is a one-cycle pulse.
    logic       pg_in;
    logic       fault_clr;
    logic       pg_ok;
    logic       rst_out_n;
    logic       pg_lost;
    logic [7:0] fault_cnt;
    logic [1:0] dbg_state;

    modport master (
        output pg_in,
        output fault_clr,
        input  pg_ok,
        input  rst_out_n,
        input  pg_lost,
        input  fault_cnt,
        input  dbg_state
    );

    modport slave (
        input  pg_in,
        input  fault_clr,
        output pg_ok,
        output rst_out_n,
        output pg_lost,
        output fault_cnt,
        output dbg_state
    );
endinterface

// File: rtl/pwr_good_rst_seq.sv
// Qualifies an asynchronous power-good level (synchronize, debounce, hold) and releases a
// sequenced active-low reset. It also reports loss of the level and counts those events.
module pwr_good_rst_seq #(
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int RELEASE_DELAY   = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    pwr_good_rst_seq_if.slave    bus
);

    localparam int DEB_W  = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int HOLD_W = $clog2(RELEASE_DELAY + 1);

    localparam logic [DEB_W-1:0]  DEB_MAX  = DEB_W'(DEBOUNCE_CYCLES);
    localparam logic [HOLD_W-1:0] HOLD_MAX = HOLD_W'(RELEASE_DELAY);
    localparam logic [DEB_W-1:0]  DEB_ONE  = DEB_W'(1);
    localparam logic [HOLD_W-1:0] HOLD_ONE = HOLD_W'(1);

    typedef enum logic [1:0] {
        ST_OFF      = 2'd0,
        ST_DEBOUNCE = 2'd1,
        ST_HOLD     = 2'd2,
        ST_ON       = 2'd3
    } state_t;

    state_t              state_q, state_nxt;
    logic [DEB_W-1:0]    deb_cnt_q, deb_cnt_nxt;
    logic [HOLD_W-1:0]   hold_cnt_q, hold_cnt_nxt;
    logic [SYNC_STAGES-1:0] sync_q;
    logic                s;
    logic                lost_evt;

    logic                pg_ok_q;
    logic                rst_out_n_q;
    logic                pg_lost_q;
    logic [7:0]          fault_cnt_q;

    // Plain shift-register synchronizer; s is the only copy of pg_in the FSM sees.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], bus.pg_in};
        end
    end

    assign s = sync_q[SYNC_STAGES-1];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_OFF;
            deb_cnt_q  <= '0;
            hold_cnt_q <= '0;
        end else begin
            state_q    <= state_nxt;
            deb_cnt_q  <= deb_cnt_nxt;
            hold_cnt_q <= hold_cnt_nxt;
        end
    end

    always_comb begin
        state_nxt    = state_q;
        deb_cnt_nxt  = deb_cnt_q;
        hold_cnt_nxt = hold_cnt_q;
        lost_evt     = 1'b0;

        unique case (state_q)
            ST_OFF: begin
                if (s) begin
                    deb_cnt_nxt  = DEB_ONE;
                    hold_cnt_nxt = '0;
                    // A single-sample debounce is already satisfied by this sample.
                    state_nxt    = (DEB_ONE == DEB_MAX) ? ST_HOLD : ST_DEBOUNCE;
                end
            end
            ST_DEBOUNCE: begin
                if (s) begin
                    deb_cnt_nxt = deb_cnt_q + DEB_ONE;
                    if (deb_cnt_q + DEB_ONE == DEB_MAX) begin
                        state_nxt    = ST_HOLD;
                        hold_cnt_nxt = '0;
                    end
                end else begin
                    state_nxt   = ST_OFF;
                    deb_cnt_nxt = '0;
                end
            end
            ST_HOLD: begin
                if (s) begin
                    hold_cnt_nxt = hold_cnt_q + HOLD_ONE;
                    if (hold_cnt_q + HOLD_ONE == HOLD_MAX) begin
                        state_nxt = ST_ON;
                    end
                end else begin
                    state_nxt    = ST_OFF;
                    deb_cnt_nxt  = '0;
                    hold_cnt_nxt = '0;
                end
            end
            ST_ON: begin
                if (!s) begin
                    state_nxt    = ST_OFF;
                    deb_cnt_nxt  = '0;
                    hold_cnt_nxt = '0;
                    lost_evt     = 1'b1;
                end
            end
            default: begin
                state_nxt    = ST_OFF;
                deb_cnt_nxt  = '0;
                hold_cnt_nxt = '0;
            end
        endcase
    end

    // The outputs are flops loaded from the next-state decode, so they change on the same
    // edge as the state register and never see pg_in combinationally.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pg_ok_q     <= 1'b0;
            rst_out_n_q <= 1'b0;
            pg_lost_q   <= 1'b0;
        end else begin
            pg_ok_q     <= (state_nxt == ST_HOLD) || (state_nxt == ST_ON);
            rst_out_n_q <= (state_nxt == ST_ON);
            pg_lost_q   <= lost_evt;
        end
    end

    // A clear landing on the same edge as a loss event still records that loss.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fault_cnt_q <= 8'd0;
        end else if (bus.fault_clr) begin
            fault_cnt_q <= lost_evt ? 8'd1 : 8'd0;
        end else if (lost_evt && (fault_cnt_q != 8'hFF)) begin
            fault_cnt_q <= fault_cnt_q + 8'd1;
        end
    end

    assign bus.pg_ok     = pg_ok_q;
    assign bus.rst_out_n = rst_out_n_q;
    assign bus.pg_lost   = pg_lost_q;
    assign bus.fault_cnt = fault_cnt_q;
    assign bus.dbg_state = state_q;

endmodule

// File: tb/tb_pwr_good_rst_seq.sv
// Directed bench for pwr_good_rst_seq with default parameters. The bench drives inputs and
// samples outputs 1ns after each rising clock edge.
module tb_pwr_good_rst_seq;

    logic clk;
    logic rst_n;
    int   n_checks;
    int   n_fail;
    int   exp_fault;

    pwr_good_rst_seq_if bus ();

    pwr_good_rst_seq #(
        .SYNC_STAGES    (2),
        .DEBOUNCE_CYCLES(16),
        .RELEASE_DELAY  (8)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Raises pg_in. The next edge is E0. pg_ok must rise after E17 and rst_out_n after E25.
    task automatic qualify(input string tag);
        bus.pg_in = 1'b1;
        repeat (17) tick();
        chk({tag, "_pgok_e16"}, {31'd0, bus.pg_ok}, 32'd0);
        tick();
        chk({tag, "_pgok_e17"}, {31'd0, bus.pg_ok}, 32'd1);
        chk({tag, "_rst_e17"}, {31'd0, bus.rst_out_n}, 32'd0);
        repeat (7) tick();
        chk({tag, "_rst_e24"}, {31'd0, bus.rst_out_n}, 32'd0);
        tick();
        chk({tag, "_rst_e25"}, {31'd0, bus.rst_out_n}, 32'd1);
        chk({tag, "_lost_e25"}, {31'd0, bus.pg_lost}, 32'd0);
        chk({tag, "_fcnt_e25"}, {24'd0, bus.fault_cnt}, exp_fault);
    endtask

    // Drops pg_in while ON. The next edge is F0. The loss must show after F2 and clear after F3.
    task automatic drop(input string tag);
        bus.pg_in = 1'b0;
        repeat (2) tick();
        chk({tag, "_rst_f1"}, {31'd0, bus.rst_out_n}, 32'd1);
        chk({tag, "_lost_f1"}, {31'd0, bus.pg_lost}, 32'd0);
        tick();
        if (exp_fault < 255) exp_fault++;
        chk({tag, "_pgok_f2"}, {31'd0, bus.pg_ok}, 32'd0);
        chk({tag, "_rst_f2"}, {31'd0, bus.rst_out_n}, 32'd0);
        chk({tag, "_lost_f2"}, {31'd0, bus.pg_lost}, 32'd1);
        chk({tag, "_fcnt_f2"}, {24'd0, bus.fault_cnt}, exp_fault);
        tick();
        chk({tag, "_lost_f3"}, {31'd0, bus.pg_lost}, 32'd0);
    endtask

    initial begin
        n_checks      = 0;
        n_fail        = 0;
        exp_fault     = 0;
        rst_n         = 1'b0;
        bus.pg_in     = 1'b0;
        bus.fault_clr = 1'b0;
        repeat (3) tick();
        chk("rst_pgok", {31'd0, bus.pg_ok}, 32'd0);
        chk("rst_rstout", {31'd0, bus.rst_out_n}, 32'd0);
        chk("rst_lost", {31'd0, bus.pg_lost}, 32'd0);
        chk("rst_fcnt", {24'd0, bus.fault_cnt}, 32'd0);
        rst_n = 1'b1;
        tick();

        // Test 1: plain qualification from reset.
        qualify("t1");

        // Test 3: loss while ON, then re-qualification.
        drop("t3");
        qualify("t3_requal");
        drop("t3b");

        // Test 2: 10 high samples, 3 low, then high again; qualification restarts.
        repeat (3) tick();
        bus.pg_in = 1'b1;
        repeat (10) tick();
        bus.pg_in = 1'b0;
        repeat (3) tick();
        chk("t2_glitch_pgok", {31'd0, bus.pg_ok}, 32'd0);
        chk("t2_glitch_state", {30'd0, bus.dbg_state}, 32'd0);
        qualify("t2");
        drop("t2_end");

        // Test 4: drop during HOLD. The low is captured at E20 and pg_ok falls after E22.
        repeat (3) tick();
        bus.pg_in = 1'b1;
        repeat (18) tick();
        chk("t4_pgok_e17", {31'd0, bus.pg_ok}, 32'd1);
        chk("t4_state_hold", {30'd0, bus.dbg_state}, 32'd2);
        repeat (2) tick();
        bus.pg_in = 1'b0;
        repeat (2) tick();
        chk("t4_pgok_e21", {31'd0, bus.pg_ok}, 32'd1);
        tick();
        chk("t4_pgok_e22", {31'd0, bus.pg_ok}, 32'd0);
        chk("t4_rst_e22", {31'd0, bus.rst_out_n}, 32'd0);
        chk("t4_lost_e22", {31'd0, bus.pg_lost}, 32'd0);
        tick();
        chk("t4_lost_e23", {31'd0, bus.pg_lost}, 32'd0);
        chk("t4_fcnt", {24'd0, bus.fault_cnt}, exp_fault);

        // fault_clr while ON must not disturb the FSM.
        qualify("t5_pre");
        bus.fault_clr = 1'b1;
        tick();
        bus.fault_clr = 1'b0;
        exp_fault = 0;
        chk("t5_clr_on_fcnt", {24'd0, bus.fault_cnt}, 32'd0);
        chk("t5_clr_on_rst", {31'd0, bus.rst_out_n}, 32'd1);
        tick();
        chk("t5_clr_on_rst2", {31'd0, bus.rst_out_n}, 32'd1);

        // Test 5: 260 ON-to-OFF cycles saturate the counter at 255.
        for (int i = 0; i < 260; i++) begin
            bus.pg_in = 1'b0;
            repeat (4) tick();
            bus.pg_in = 1'b1;
            repeat (26) tick();
            if (i == 253) chk("t5_fcnt_254", {24'd0, bus.fault_cnt}, 32'd254);
        end
        chk("t5_on_after_loop", {31'd0, bus.rst_out_n}, 32'd1);
        chk("t5_fcnt_sat", {24'd0, bus.fault_cnt}, 32'd255);
        bus.fault_clr = 1'b1;
        tick();
        bus.fault_clr = 1'b0;
        chk("t5_fcnt_clr", {24'd0, bus.fault_cnt}, 32'd0);
        // fault_clr on the same edge (F2) as the loss.
        bus.pg_in = 1'b0;
        repeat (2) tick();
        bus.fault_clr = 1'b1;
        tick();
        bus.fault_clr = 1'b0;
        chk("t5_coinc_lost", {31'd0, bus.pg_lost}, 32'd1);
        chk("t5_coinc_fcnt", {24'd0, bus.fault_cnt}, 32'd1);
        exp_fault = 1;

        // Test 6: reset asserted mid-HOLD after E21 with pg_in held high.
        repeat (3) tick();
        bus.pg_in = 1'b1;
        repeat (22) tick();
        chk("t6_pgok_pre", {31'd0, bus.pg_ok}, 32'd1);
        rst_n = 1'b0;
        #1;
        chk("t6_async_pgok", {31'd0, bus.pg_ok}, 32'd0);
        chk("t6_async_rst", {31'd0, bus.rst_out_n}, 32'd0);
        chk("t6_async_lost", {31'd0, bus.pg_lost}, 32'd0);
        chk("t6_async_fcnt", {24'd0, bus.fault_cnt}, 32'd0);
        exp_fault = 0;
        repeat (2) tick();
        rst_n = 1'b1;
        qualify("t6_post");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
